// File: rtl/axil_rr_arbiter.sv
// Two-master / one-slave AXI4-Lite arbiter with round-robin fairness.
// Master 0 (IFU) and master 1 (LSU) share one downstream port. Whole
// transactions are serialized (AR->R or AW+W->B), and the grant is held until
// the response handshake completes.
// Ports: clock/reset (sync, active-high); m0_*/m1_* master-side AXI4-Lite
// slave ports; s_* downstream AXI4-Lite master port; grant_id/busy status.
// Optional feature: define AXIL_ARB_TIMEOUT_EN to enable a watchdog that
// answers a stalled transaction with an error response after TIMEOUT cycles.
module axil_rr_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                clock,
  input  logic                reset,
  // master 0
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  // master 1
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  // slave
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  // status
  output logic                grant_id,
  output logic                busy
);

  localparam int unsigned STRB_W = DATA_W / 8;
`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
`ifdef AXIL_ARB_TIMEOUT_EN
    , S_ERR = 2'd3
`endif
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;
`ifdef AXIL_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, rd_d;
`endif

  // Granted-master request signals
  logic [ADDR_W-1:0] g_araddr, g_awaddr;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;
  logic              g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;

  assign g_araddr  = grant_q ? m1_araddr  : m0_araddr;
  assign g_arvalid = grant_q ? m1_arvalid : m0_arvalid;
  assign g_rready  = grant_q ? m1_rready  : m0_rready;
  assign g_awaddr  = grant_q ? m1_awaddr  : m0_awaddr;
  assign g_awvalid = grant_q ? m1_awvalid : m0_awvalid;
  assign g_wdata   = grant_q ? m1_wdata   : m0_wdata;
  assign g_wstrb   = grant_q ? m1_wstrb   : m0_wstrb;
  assign g_wvalid  = grant_q ? m1_wvalid  : m0_wvalid;
  assign g_bready  = grant_q ? m1_bready  : m0_bready;

  // Round-robin pick: on a tie the master that did not go last wins
  logic req0, req1, pick, pick_rd;
  assign req0    = m0_arvalid | m0_awvalid;
  assign req1    = m1_arvalid | m1_awvalid;
  assign pick    = (req0 & req1) ? ~last_q : req1;
  assign pick_rd = pick ? m1_arvalid : m0_arvalid;

  // Response signals headed to whichever master holds the grant
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp, r_bresp;
  logic              r_arready, r_rvalid, r_awready, r_wready, r_bvalid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      rd_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
`ifdef AXIL_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    rd_d      = rd_q;
`endif
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    r_arready = 1'b0;
    r_rdata   = '0;
    r_rresp   = 2'b00;
    r_rvalid  = 1'b0;
    r_awready = 1'b0;
    r_wready  = 1'b0;
    r_bresp   = 2'b00;
    r_bvalid  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          grant_d = pick;
          state_d = pick_rd ? S_RD : S_WR;
`ifdef AXIL_ARB_TIMEOUT_EN
          rd_d    = pick_rd;
`endif
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        // Drain late responses of timed-out transactions
        cnt_d    = '0;
        s_rready = 1'b1;
        s_bready = 1'b1;
`endif
      end
      S_RD: begin
        s_araddr  = g_araddr;
        s_arvalid = g_arvalid;
        s_rready  = g_rready;
        r_arready = s_arready;
        r_rdata   = s_rdata;
        r_rresp   = s_rresp;
        r_rvalid  = s_rvalid;
        if (s_rvalid & g_rready) begin
          state_d = S_IDLE;
          last_d  = grant_q;
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT)) state_d = S_ERR;
        end
`endif
      end
      S_WR: begin
        s_awaddr  = g_awaddr;
        s_awvalid = g_awvalid;
        s_wdata   = g_wdata;
        s_wstrb   = g_wstrb;
        s_wvalid  = g_wvalid;
        s_bready  = g_bready;
        r_awready = s_awready;
        r_wready  = s_wready;
        r_bresp   = s_bresp;
        r_bvalid  = s_bvalid;
        if (s_bvalid & g_bready) begin
          state_d = S_IDLE;
          last_d  = grant_q;
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT)) state_d = S_ERR;
        end
`endif
      end
`ifdef AXIL_ARB_TIMEOUT_EN
      S_ERR: begin
        // Slave side stays quiet; master gets a DECERR-style response
        if (rd_q) begin
          r_rvalid = 1'b1;
          r_rresp  = 2'b11;
          if (g_rready) begin
            state_d = S_IDLE;
            last_d  = grant_q;
          end
        end else begin
          r_bvalid = 1'b1;
          r_bresp  = 2'b11;
          if (g_bready) begin
            state_d = S_IDLE;
            last_d  = grant_q;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Route responses to the granted master only
  assign m0_arready = ~grant_q & r_arready;
  assign m0_rdata   = grant_q ? '0 : r_rdata;
  assign m0_rresp   = grant_q ? 2'b00 : r_rresp;
  assign m0_rvalid  = ~grant_q & r_rvalid;
  assign m0_awready = ~grant_q & r_awready;
  assign m0_wready  = ~grant_q & r_wready;
  assign m0_bresp   = grant_q ? 2'b00 : r_bresp;
  assign m0_bvalid  = ~grant_q & r_bvalid;

  assign m1_arready = grant_q & r_arready;
  assign m1_rdata   = grant_q ? r_rdata : '0;
  assign m1_rresp   = grant_q ? r_rresp : 2'b00;
  assign m1_rvalid  = grant_q & r_rvalid;
  assign m1_awready = grant_q & r_awready;
  assign m1_wready  = grant_q & r_wready;
  assign m1_bresp   = grant_q ? r_bresp : 2'b00;
  assign m1_bvalid  = grant_q & r_bvalid;

  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: doc/axil_rr_arbiter.md
Name: axil_rr_arbiter

Overview:
- Two-master, one-slave AXI4-Lite arbiter with round-robin fairness.
- Sits between the IFU (master 0) and LSU (master 1) and the shared downstream memory/peripheral port.
- Serializes whole transactions: one read (AR→R) or one write (AW+W→B) at a time.
- Grant is held until the response handshake completes.

Parameters:
- ADDR_W, 32, address width of all AR/AW channels
- DATA_W, 32, data width of R/W channels; wstrb width is DATA_W/8
- TIMEOUT, 1023, watchdog limit in cycles (used only with the optional feature)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mN_araddr/mN_arvalid/mN_arready  in/in/out  ADDR_W/1/1  master N read address channel (N=0,1)
- mN_rdata/mN_rresp/mN_rvalid/mN_rready  out/out/out/in  DATA_W/2/1/1  master N read data channel
- mN_awaddr/mN_awvalid/mN_awready  in/in/out  ADDR_W/1/1  master N write address channel
- mN_wdata/mN_wstrb/mN_wvalid/mN_wready  in/in/in/out  DATA_W/DATA_W/8/1/1  master N write data channel
- mN_bresp/mN_bvalid/mN_bready  out/out/in  2/1/1  master N write response channel
- s_araddr/s_arvalid/s_arready  out/out/in  ADDR_W/1/1  slave read address channel
- s_rdata/s_rresp/s_rvalid/s_rready  in/in/in/out  DATA_W/2/1/1  slave read data channel
- s_awaddr/s_awvalid/s_awready  out/out/in  ADDR_W/1/1  slave write address channel
- s_wdata/s_wstrb/s_wvalid/s_wready  out/out/out/in  DATA_W/DATA_W/8/1/1  slave write data channel
- s_bresp/s_bvalid/s_bready  in/in/out  2/1/1  slave write response channel
- grant_id  out  1  currently granted master (valid when busy=1)
- busy  out  1  1 when state != IDLE

Behaviour:
- States:
  - IDLE
  - RD (read in progress)
  - WR (write in progress)
  - ERR (error response to the granted master; optional feature only)
- Reset:
  - state=IDLE, last=1 (master 0 wins the first tie), grant_id=0, watchdog count=0.
  - All master- and slave-side outputs are 0.
  - Reset mid-transaction abandons the transaction with no response.
- IDLE arbitration:
  - req_N = mN_arvalid | mN_awvalid.
  - If both masters request, grant the master != last; otherwise grant the single requester.
  - Within the granted master, a read (arvalid) has priority over a write.
  - Transition to RD or WR at the next edge. Grant latency is 1 cycle; no slave valid is asserted in IDLE.
- RD:
  - Granted master's AR and R signals are connected combinationally to the slave.
  - All AW/W/B outputs to both sides are 0.
  - The non-granted master sees all readies and valids at 0 and rdata/bresp at 0.
  - Exit to IDLE at the edge where s_rvalid & s_rready are both 1; set last=grant_id.
- WR:
  - Granted master's AW, W and B signals are connected combinationally.
  - AR/R outputs are 0.
  - AW and W may handshake in any order or in the same cycle.
  - Exit to IDLE on s_bvalid & s_bready; set last=grant_id.
- Back-to-back requests:
  - Re-arbitration happens in the IDLE cycle after completion.
  - Minimum cost is 1 dead cycle between transactions.
- Strict fairness:
  - Under continuous requests from both masters, grants alternate 0,1,0,1.
- Stray slave responses:
  - An s_rvalid in WR or s_bvalid in RD is not acknowledged (s_rready/s_bready = 0).
- Master valids:
  - Sampled only in IDLE.
  - Dropping a valid before its handshake is a protocol violation; behaviour is undefined.

Optional Feature:
- Macro: AXIL_ARB_TIMEOUT_EN.
- Enabled:
  - Watchdog counter clears on entering RD/WR and increments each cycle in RD/WR.
  - When the count reaches TIMEOUT with no completion, transition to ERR.
  - ERR:
    - All slave-side valids and readies are 0.
    - Granted master sees rvalid=1, rresp=2'b11, rdata=0 (timed-out read), or bvalid=1, bresp=2'b11 (timed-out write).
    - Held until the master's ready; then go to IDLE and set last.
  - In IDLE, s_rready=s_bready=1 so late slave responses are drained.
  - Completion and timeout in the same cycle: completion wins.
- Disabled:
  - No counter and no ERR state.
  - A stalled slave holds the grant indefinitely.
  - s_rready/s_bready are 0 in IDLE.

Test Plan:
- Reset, then m0 araddr=0x3000_0000 arvalid=1 → grant_id=0, s_arvalid=1 at cycle 1; slave returns rdata=0x1234_5678 → m0_rdata=0x1234_5678, m0_rvalid=1, m1_rvalid=0; busy=0 next cycle.
- m0 arvalid and m1 awvalid asserted in the same cycle after reset → m0 read served first, m1 write second. Continuous requests for 6 transactions → grant order 0,1,0,1,0,1.
- m1 write awaddr=0x8000_0010 wdata=0xDEAD_BEEF wstrb=4'b0011, slave asserts awready 2 cycles before wready → s_wstrb=4'b0011; m1_bvalid=1 with bresp=0 on the slave B handshake; no AR activity.
- m1 asserts arvalid and awvalid together → read completes before the write is issued; m1_awready stays 0 during RD.
- AXIL_ARB_TIMEOUT_EN with TIMEOUT=16, slave never asserts rvalid → m0_rvalid=1, rresp=2'b11, rdata=0 at cycle 17 after grant. A late s_rvalid in IDLE is drained with s_rready=1.
- Assert reset while in WR with awvalid pending → busy=0 and all outputs 0 on the next edge; a new m0 read is granted normally afterwards.
